// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader that packs bytes into 32-bit
// instruction-memory writes and holds the core in reset until the load completes.
module imem_loader #(
  parameter int IMEM_WORDS = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(IMEM_WORDS);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_lane;
  logic [ADDR_W:0]   r_index;
  logic [31:0]       r_word;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_hs;
  logic              w_complete;
  logic              w_overflow;
  logic              w_restart;
  logic [31:0]       w_merged;

  assign w_hs       = in_valid && (r_state == S_LOAD);
  assign w_complete = w_hs && (in_last || (r_lane == 2'd3));
  assign w_overflow = (r_index == LP_FULL);
  assign w_restart  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  // Lanes above the current one are always zero in r_word, so a short final word is zero-filled.
  assign w_merged   = r_word | ({24'd0, in_data} << {r_lane, 3'b000});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (w_complete && w_overflow) begin
          w_next = S_ERR;
        end else if (w_hs && in_last) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
        if (start) w_next = S_LOAD;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) w_next = S_LOAD;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane  <= 2'd0;
      r_index <= '0;
      r_word  <= 32'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else begin
      r_we <= 1'b0;
      if (w_restart) begin
        r_lane  <= 2'd0;
        r_index <= '0;
        r_word  <= 32'd0;
      end else if (w_complete) begin
        r_lane <= 2'd0;
        r_word <= 32'd0;
        if (!w_overflow) begin
          r_we    <= 1'b1;
          r_addr  <= r_index[ADDR_W-1:0];
          r_wdata <= w_merged;
          r_index <= r_index + (ADDR_W+1)'(1);
        end
      end else if (w_hs) begin
        r_lane <= r_lane + 2'd1;
        r_word <= w_merged;
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized and directed checks of imem_loader against a
// word-packing reference model, using a 64-word and a 4-word instance.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  int          sel;

  logic        a_start, a_valid, a_ready, a_we, a_cr, a_done, a_err;
  logic [5:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_start, b_valid, b_ready, b_we, b_cr, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;

  logic        m_ready, m_we, m_cr, m_done, m_err;
  logic [31:0] m_addr, m_wdata;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          last_hs_cyc;
  int          done_cyc;
  int          hs_n;
  logic        prev_done = 1'b0;
  logic [7:0]  prog[$];

  always #5 clk = ~clk;

  assign a_start = (sel == 0) && start;
  assign a_valid = (sel == 0) && in_valid;
  assign b_start = (sel == 1) && start;
  assign b_valid = (sel == 1) && in_valid;

  assign m_ready = (sel == 1) ? b_ready : a_ready;
  assign m_we    = (sel == 1) ? b_we    : a_we;
  assign m_cr    = (sel == 1) ? b_cr    : a_cr;
  assign m_done  = (sel == 1) ? b_done  : a_done;
  assign m_err   = (sel == 1) ? b_err   : a_err;
  assign m_addr  = (sel == 1) ? 32'(b_addr) : 32'(a_addr);
  assign m_wdata = (sel == 1) ? b_wdata : a_wdata;

  imem_loader dut64 (
    .clk(clk), .reset(reset), .start(a_start), .in_valid(a_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(a_ready), .imem_we(a_we), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .core_reset(a_cr), .done(a_done), .err(a_err)
  );

  imem_loader #(.IMEM_WORDS(4), .ADDR_W(2)) dut4 (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .core_reset(b_cr), .done(b_done), .err(b_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_we) begin
      wr_addr_q.push_back(m_addr);
      wr_data_q.push_back(m_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (in_valid && m_ready) begin
      hs_n++;
      if (in_last) last_hs_cyc = cyc;
    end
    if (m_done && !prev_done) done_cyc = cyc;
    prev_done = m_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    last_hs_cyc = -100;
    done_cyc    = -100;
    hs_n        = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, output bit ok);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    ok       = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (m_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic logic [31:0] model_word(input int i);
    logic [31:0] w = 32'd0;
    for (int j = 0; j < 4; j++)
      if (4*i + j < prog.size()) w |= 32'(prog[4*i + j]) << (8*j);
    return w;
  endfunction

  task automatic run_prog(input int s, input int gapmax, input bit do_start);
    bit ok = 1'b1;
    int n, words, cap, nw, acc;
    bit exp_err;
    sel = s;
    clear_mon();
    if (do_start) pulse_start();
    foreach (prog[i]) begin
      if (ok) begin
        repeat ($urandom_range(gapmax, 0)) begin @(posedge clk); #1; end
        send_byte(prog[i], (i == prog.size() - 1), ok);
      end
    end
    for (int t = 0; t < 10 && !(m_done || m_err); t++) begin @(posedge clk); #1; end
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    n       = prog.size();
    cap     = (s == 1) ? 4 : 64;
    words   = (n + 3) / 4;
    exp_err = words > cap;
    nw      = exp_err ? cap : words;
    acc     = (exp_err && n > 4*cap + 4) ? 4*cap + 4 : n;
    check("nwrites", wr_addr_q.size(), nw);
    check("accepted", hs_n, acc);
    for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
      check($sformatf("addr%0d", i), wr_addr_q[i], i);
      check($sformatf("data%0d", i), wr_data_q[i], model_word(i));
    end
    check("err", m_err, exp_err);
    check("done", m_done, !exp_err);
    check("core_reset", m_cr, exp_err);
    if (!exp_err && wr_cyc_q.size() > 0) begin
      check("done_lat", done_cyc - last_hs_cyc, 2);
      check("we_lat", wr_cyc_q[wr_cyc_q.size() - 1] - last_hs_cyc, 1);
    end
  endtask

  task automatic load_req029();
    prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h70, 8'h00};
  endtask

  initial begin
    bit ok;
    sel      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready64", a_ready, 1'b0);
    check("rst_ready4", b_ready, 1'b0);
    check("rst_we", a_we, 1'b0);
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_wdata", a_wdata, 32'd0);
    check("rst_cr", a_cr, 1'b1);
    check("rst_done", a_done, 1'b0);
    check("rst_err", b_err, 1'b0);
    check("idle_hs", hs_n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    load_req029();
    run_prog(0, 0, 1'b1);

    pulse_start();
    @(negedge clk);
    check("restart_cr", m_cr, 1'b1);
    check("restart_done", m_done, 1'b0);
    check("restart_ready", m_ready, 1'b1);
    @(posedge clk); #1;
    load_req029();
    run_prog(0, 0, 1'b1);

    prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hAA};
    run_prog(0, 0, 1'b1);

    load_req029();
    run_prog(0, 3, 1'b1);

    prog.delete();
    for (int i = 0; i < 17; i++) prog.push_back(8'($urandom));
    run_prog(1, 1, 1'b1);

    sel = 0;
    clear_mon();
    pulse_start();
    send_byte(8'h11, 1'b0, ok);
    send_byte(8'h22, 1'b0, ok);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid_we", wr_addr_q.size(), 0);
    check("rst_mid_ready", m_ready, 1'b0);
    check("rst_mid_cr", m_cr, 1'b1);
    @(posedge clk); #1;
    load_req029();
    run_prog(0, 0, 1'b1);

    for (int k = 0; k < 24; k++) begin
      int s = $urandom_range(1, 0);
      int n = $urandom_range(s ? 24 : 40, 1);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
      run_prog(s, 2, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
